mux_3in_1out: RTL and testbench
===============================

Name: mux_3in_1out

Overview:
- Registered 3-to-1 data selector for datapath operand or result steering (e.g. ALU-input / write-back source select).
- Selects one of three WIDTH-bit inputs by a 2-bit select and presents it on a registered output one clock later.
- Illegal select code 3 is trapped and flagged.
- One clock domain; asynchronous active-low reset.

Parameters:
- WIDTH, 32, data width of DatoA/DatoB/DatoC/Salida.
- ILLEGAL_VAL, 0, value loaded into Salida when Sel = 3 (truncated to WIDTH).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- DatoA  input  WIDTH  source selected by Sel = 0.
- DatoB  input  WIDTH  source selected by Sel = 1.
- DatoC  input  WIDTH  source selected by Sel = 2.
- Sel  input  2  select code.
- En  input  1  capture enable; when 0 the output register holds.
- Salida  output  WIDTH  registered selected data.
- SelErr  output  1  registered flag: last captured Sel was 3.

Behaviour:
- Reset: rst_n low asynchronously forces Salida = 0 and SelErr = 0, regardless of clk. Values hold while rst_n is low.
- Release of rst_n is not itself an event; the first capture is on the first rising edge with rst_n = 1 and En = 1.
- Capture on a rising clk edge with En = 1:
  - Sel = 0: Salida <= DatoA
  - Sel = 1: Salida <= DatoB
  - Sel = 2: Salida <= DatoC
  - Sel = 3: Salida <= ILLEGAL_VAL
  - SelErr <= (Sel == 3)
- En = 0: Salida and SelErr hold their previous values.
- Latency: exactly 1 cycle from input/Sel change to Salida change; no combinational path from any input to Salida or SelErr.
- Data passes bit-exact, with no sign handling or width conversion.
- Sel and data are sampled on the same edge. A Sel change and a data change on the same edge use the new values of both.
- Reset asserted mid-operation clears the outputs immediately. Captured data from before reset is lost.

Optional Feature:
- Macro: MUX3_STICKY_ERR_EN.
- Defined:
  - SelErr becomes sticky: set on any capture with Sel = 3 and held until rst_n is asserted or an added input ErrClr (1 bit, synchronous) is high on a rising edge.
  - Set has priority over clear when both occur on the same edge.
- Undefined:
  - ErrClr port is absent.
  - SelErr reflects only the most recent capture, as in Behaviour.

Decomposition:
- Shared package mux3_pkg:
  - Select-code constants SEL_A = 2'd0, SEL_B = 2'd1, SEL_C = 2'd2, SEL_ILLEGAL = 2'd3.
  - Default WIDTH constant 32.
- Natural sub-module: mux3_sel_comb, a purely combinational 3:1 selector plus illegal-code detect. The top module wraps it with the enable/reset register stage.

Test Plan:
- Reset: rst_n = 0 with DatoA = 2, Sel = 0, clocks running -> Salida = 0, SelErr = 0. Assert rst_n mid-cycle -> outputs clear without waiting for a clock edge.
- Selection: DatoA = 2, DatoB = 4, DatoC = 6, En = 1; Sel = 0, then 1, then 2 on successive edges -> Salida = 2, 4, 6, each one cycle after the corresponding Sel; SelErr = 0.
- Illegal select: Sel = 3 -> Salida = ILLEGAL_VAL (0) and SelErr = 1 next cycle. Then Sel = 1 -> Salida = 4, SelErr = 0 (non-sticky build).
- Enable hold: Salida = 6; set En = 0, change Sel to 0 and DatoC to 9 -> Salida stays 6 and SelErr stays unchanged. Re-enable -> Salida = 2 next edge.
- Width extremes: DatoB = 32'hFFFF_FFFF, Sel = 1 -> Salida = 32'hFFFF_FFFF. DatoC = 32'h8000_0001, Sel = 2 -> Salida = 32'h8000_0001.
- Sticky build (MUX3_STICKY_ERR_EN):
  - Sel = 3, then Sel = 0 -> SelErr remains 1.
  - ErrClr = 1 with Sel = 0 -> SelErr = 0.
  - ErrClr = 1 with Sel = 3 on the same edge -> SelErr = 1.

Source files
------------

// File: rtl/mux3_pkg.sv
// Shared constants for the registered 3:1 selector: select codes and default data width.
package mux3_pkg;

    localparam int unsigned MUX3_WIDTH = 32;

    localparam logic [1:0] SEL_A       = 2'd0;
    localparam logic [1:0] SEL_B       = 2'd1;
    localparam logic [1:0] SEL_C       = 2'd2;
    localparam logic [1:0] SEL_ILLEGAL = 2'd3;

endpackage : mux3_pkg

// File: rtl/mux3_sel_comb.sv
// Purely combinational 3:1 data selector with illegal select-code detection.
module mux3_sel_comb
    import mux3_pkg::*;
#(
    parameter int unsigned WIDTH = MUX3_WIDTH
) (
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    input  logic [WIDTH-1:0] data_c,
    input  logic [WIDTH-1:0] illegal_val,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] data_o,
    output logic             illegal_o
);

    // Route the addressed source; the unused code yields the trap value.
    always_comb begin
        data_o    = illegal_val;
        illegal_o = 1'b0;
        case (sel)
            SEL_A: data_o = data_a;
            SEL_B: data_o = data_b;
            SEL_C: data_o = data_c;
            SEL_ILLEGAL: begin
                data_o    = illegal_val;
                illegal_o = 1'b1;
            end
            default: begin
                data_o    = illegal_val;
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule : mux3_sel_comb

// File: rtl/mux_3in_1out.sv
// Registered 3:1 selector with illegal-select flag; one cycle latency, enable-gated capture.
// Optional MUX3_STICKY_ERR_EN makes SelErr sticky until cleared by ErrClr or reset.
module mux_3in_1out
    import mux3_pkg::*;
#(
    parameter int unsigned     WIDTH       = MUX3_WIDTH,
    parameter logic [WIDTH-1:0] ILLEGAL_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] DatoA,
    input  logic [WIDTH-1:0] DatoB,
    input  logic [WIDTH-1:0] DatoC,
    input  logic [1:0]       Sel,
    input  logic             En,
`ifdef MUX3_STICKY_ERR_EN
    input  logic             ErrClr,
`endif
    output logic [WIDTH-1:0] Salida,
    output logic             SelErr
);

    logic [WIDTH-1:0] mux_data_s;
    logic             illegal_s;
    logic [WIDTH-1:0] salida_d;
    logic [WIDTH-1:0] salida_q;
    logic             sel_err_d;
    logic             sel_err_q;

    mux3_sel_comb #(
        .WIDTH(WIDTH)
    ) u_sel (
        .data_a     (DatoA),
        .data_b     (DatoB),
        .data_c     (DatoC),
        .illegal_val(ILLEGAL_VAL),
        .sel        (Sel),
        .data_o     (mux_data_s),
        .illegal_o  (illegal_s)
    );

    // Next-state: capture on enable, otherwise hold; sticky flag set wins over clear.
    always_comb begin
        salida_d  = salida_q;
        sel_err_d = sel_err_q;
        if (En) begin
            salida_d = mux_data_s;
        end else begin
            salida_d = salida_q;
        end
`ifdef MUX3_STICKY_ERR_EN
        if (En && illegal_s) begin
            sel_err_d = 1'b1;
        end else if (ErrClr) begin
            sel_err_d = 1'b0;
        end else begin
            sel_err_d = sel_err_q;
        end
`else
        if (En) begin
            sel_err_d = illegal_s;
        end else begin
            sel_err_d = sel_err_q;
        end
`endif
    end

    // Output register stage with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            salida_q  <= '0;
            sel_err_q <= 1'b0;
        end else begin
            salida_q  <= salida_d;
            sel_err_q <= sel_err_d;
        end
    end

    assign Salida = salida_q;
    assign SelErr = sel_err_q;

endmodule : mux_3in_1out

// File: tb/tb_mux_3in_1out.sv
// Scoreboard bench for mux_3in_1out: driver queues hand-computed expectations, monitor compares.
module tb_mux_3in_1out;

    localparam int unsigned W = 32;

    logic          clk;
    logic          rst_n;
    logic [W-1:0]  DatoA;
    logic [W-1:0]  DatoB;
    logic [W-1:0]  DatoC;
    logic [1:0]    Sel;
    logic          En;
    logic          ErrClr;
    logic [W-1:0]  Salida;
    logic          SelErr;

    typedef struct packed {
        logic [W-1:0] sal;
        logic         err;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec;
    int   n_err;

    mux_3in_1out #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .DatoA (DatoA),
        .DatoB (DatoB),
        .DatoC (DatoC),
        .Sel   (Sel),
        .En    (En),
`ifdef MUX3_STICKY_ERR_EN
        .ErrClr(ErrClr),
`endif
        .Salida(Salida),
        .SelErr(SelErr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: one registered result per edge following a queued vector.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_vec = n_vec + 1;
            if (Salida !== e.sal || SelErr !== e.err) begin
                n_err = n_err + 1;
                $display("FAIL vec%0d: Salida=%h SelErr=%b, required Salida=%h SelErr=%b",
                         n_vec, Salida, SelErr, e.sal, e.err);
            end
        end
    end

    task automatic direct_check(input string name, input logic [W-1:0] sal, input logic err);
        n_vec = n_vec + 1;
        if (Salida !== sal || SelErr !== err) begin
            n_err = n_err + 1;
            $display("FAIL %s: Salida=%h SelErr=%b, required Salida=%h SelErr=%b",
                     name, Salida, SelErr, sal, err);
        end
    endtask

    task automatic vec(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                       input logic [1:0] s, input logic en, input logic clr,
                       input logic [W-1:0] exp_sal, input logic exp_err);
        exp_t e;
        @(negedge clk);
        DatoA  = a;
        DatoB  = b;
        DatoC  = c;
        Sel    = s;
        En     = en;
        ErrClr = clr;
        e.sal  = exp_sal;
        e.err  = exp_err;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
            #2;
        end
        if (exp_q.size() != 0) begin
            n_vec = n_vec + 1;
            n_err = n_err + 1;
            $display("FAIL drain: %0d results pending, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        n_vec  = 0;
        n_err  = 0;
        rst_n  = 1'b0;
        DatoA  = 32'd2;
        DatoB  = 32'd4;
        DatoC  = 32'd6;
        Sel    = 2'd0;
        En     = 1'b1;
        ErrClr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        direct_check("reset_hold", 32'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        vec(32'd2, 32'd4, 32'd6, 2'd0, 1'b1, 1'b0, 32'd2, 1'b0);
        vec(32'd2, 32'd4, 32'd6, 2'd1, 1'b1, 1'b0, 32'd4, 1'b0);
        vec(32'd2, 32'd4, 32'd6, 2'd2, 1'b1, 1'b0, 32'd6, 1'b0);
        vec(32'd2, 32'd4, 32'd6, 2'd3, 1'b1, 1'b0, 32'd0, 1'b1);
`ifdef MUX3_STICKY_ERR_EN
        vec(32'd2, 32'd4, 32'd6, 2'd1, 1'b1, 1'b0, 32'd4, 1'b1);
        vec(32'd2, 32'd4, 32'd6, 2'd0, 1'b1, 1'b1, 32'd2, 1'b0);
        vec(32'd2, 32'd4, 32'd6, 2'd3, 1'b1, 1'b1, 32'd0, 1'b1);
        vec(32'd2, 32'd4, 32'd6, 2'd0, 1'b1, 1'b0, 32'd2, 1'b1);
        vec(32'd2, 32'd4, 32'd6, 2'd0, 1'b0, 1'b1, 32'd2, 1'b0);
`else
        vec(32'd2, 32'd4, 32'd6, 2'd1, 1'b1, 1'b0, 32'd4, 1'b0);
`endif
        // Enable hold: inputs change but outputs must not.
        vec(32'd2, 32'd4, 32'd6, 2'd2, 1'b1, 1'b0, 32'd6, 1'b0);
        vec(32'd2, 32'd4, 32'd9, 2'd0, 1'b0, 1'b0, 32'd6, 1'b0);
        vec(32'd2, 32'd4, 32'd9, 2'd2, 1'b0, 1'b0, 32'd6, 1'b0);
        vec(32'd2, 32'd4, 32'd9, 2'd0, 1'b1, 1'b0, 32'd2, 1'b0);
        vec(32'd2, 32'd4, 32'd9, 2'd3, 1'b1, 1'b0, 32'd0, 1'b1);
        vec(32'd2, 32'd4, 32'd9, 2'd1, 1'b0, 1'b0, 32'd0, 1'b1);
        vec(32'd2, 32'hFFFF_FFFF, 32'd9, 2'd1, 1'b1, 1'b0, 32'hFFFF_FFFF,
`ifdef MUX3_STICKY_ERR_EN
            1'b1);
`else
            1'b0);
`endif
        vec(32'd2, 32'hFFFF_FFFF, 32'h8000_0001, 2'd2, 1'b1, 1'b1, 32'h8000_0001, 1'b0);
        vec(32'hA5A5_5A5A, 32'd0, 32'd0, 2'd0, 1'b1, 1'b0, 32'hA5A5_5A5A, 1'b0);
        vec(32'd3, 32'd5, 32'd7, 2'd3, 1'b1, 1'b0, 32'd0, 1'b1);
        drain();

        // Asynchronous reset in the middle of a cycle.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        direct_check("async_reset", 32'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        vec(32'd3, 32'd5, 32'h8000_0001, 2'd2, 1'b1, 1'b0, 32'h8000_0001, 1'b0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_mux_3in_1out
